// File: rtl/dac_sample_sequencer.sv
// Sample FIFO plus a programmable-rate release timer that feeds the SPI DAC interface.
// Each tick in IDLE pops one sample and issues one start; the next pop waits for the done handshake.
module dac_sample_sequencer #(
  parameter int DEPTH = 8,
  parameter int PW    = 16
) (
  input  logic                     sclk,
  input  logic                     n_reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     enable,
  input  logic [PW-1:0]            period,
  input  logic                     clr_flags,
  input  logic                     dac_done,
  output logic [7:0]               dac_data,
  output logic                     dac_start,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     underrun,
  output logic                     missed
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [7:0]      dac_data_q, dac_data_d;
  logic [PW-1:0]   count_q, count_d;
  logic [PW-1:0]   period_eff;
  logic            underrun_q, underrun_d;
  logic            missed_q, missed_d;
  logic [7:0]      mem_q [DEPTH];
  logic            tick;
  logic            pop;
  logic            push;

  assign full  = (level_q == FULL_LEVEL);
  assign empty = (level_q == '0);
  assign level = level_q;

  // A period of zero behaves like one, so the timer can never stall.
  always_comb begin
    period_eff = (period == '0) ? PW'(1) : period;
    tick       = enable && (count_q >= (period_eff - PW'(1)));
    count_d    = count_q + PW'(1);
    if (!enable || tick) begin
      count_d = '0;
    end
  end

  always_comb begin
    pop        = (state_q == IDLE) && tick && !empty;
    push       = wr_en && (!full || pop);
    wr_ptr_d   = push ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d   = pop  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    dac_data_d = pop  ? mem_q[rd_ptr_q] : dac_data_q;
    level_d    = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Set events take priority over a simultaneous clear.
  always_comb begin
    underrun_d = underrun_q && !clr_flags;
    missed_d   = missed_q && !clr_flags;
    if ((state_q == IDLE) && tick && empty) begin
      underrun_d = 1'b1;
    end
    if ((state_q != IDLE) && tick) begin
      missed_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pop) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (dac_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (!n_reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      dac_data_q <= '0;
      count_q    <= '0;
      underrun_q <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      dac_data_q <= dac_data_d;
      count_q    <= count_d;
      underrun_q <= underrun_d;
      missed_q   <= missed_d;
    end
  end

  // Storage needs no reset; the pointers and level define what is valid.
  always_ff @(posedge sclk) begin
    if (n_reset && push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_comb begin
    dac_start = (state_q == START);
    busy      = (state_q != IDLE);
    dac_data  = dac_data_q;
    underrun  = underrun_q;
    missed    = missed_q;
  end

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Self-checking bench for dac_sample_sequencer: a directed vector table, multi-cycle
// handshake sequences and a randomized run, all compared against a queue-based model.
module tb_dac_sample_sequencer;

  localparam int DEPTH = 8;
  localparam int PW    = 16;

  logic          sclk = 1'b0;
  logic          n_reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          enable = 1'b0;
  logic [PW-1:0] period = '0;
  logic          clr_flags = 1'b0;
  logic          dac_done = 1'b0;
  logic [7:0]    dac_data;
  logic          dac_start;
  logic          full;
  logic          empty;
  logic [3:0]    level;
  logic          busy;
  logic          underrun;
  logic          missed;

  dac_sample_sequencer #(.DEPTH(DEPTH), .PW(PW)) dut (
    .sclk      (sclk),
    .n_reset   (n_reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .enable    (enable),
    .period    (period),
    .clr_flags (clr_flags),
    .dac_done  (dac_done),
    .dac_data  (dac_data),
    .dac_start (dac_start),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .busy      (busy),
    .underrun  (underrun),
    .missed    (missed)
  );

  always #5 sclk = ~sclk;

  typedef struct {
    logic        n_reset;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        enable;
    logic [15:0] period;
    logic        clr_flags;
    logic        dac_done;
    logic [7:0]  exp_data;
    logic        exp_start;
    logic [3:0]  exp_level;
    logic        exp_busy;
    logic        exp_underrun;
    logic        exp_missed;
  } vec_t;

  vec_t vecs [15];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: queue of pending samples, timer count, transfer phase
  // (0 = no transfer, 1 = start cycle, 2 = waiting for done), and the two flags.
  logic [7:0] m_q [$];
  int         m_cnt   = 0;
  int         m_phase = 0;
  logic [7:0] m_data  = 8'h00;
  bit         m_ur    = 1'b0;
  bit         m_ms    = 1'b0;

  logic [7:0] got [$];
  int         n_starts   = 0;
  int         done_cycle = -1;
  int         done_delay = 1;

  task automatic checkValue(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelStep();
    int p;
    bit tick;
    bit pop;
    bit ur_ev;
    bit ms_ev;
    bit was_full;
    if (!n_reset) begin
      m_q.delete();
      m_cnt   = 0;
      m_phase = 0;
      m_data  = 8'h00;
      m_ur    = 1'b0;
      m_ms    = 1'b0;
      return;
    end
    p        = (period == 0) ? 1 : int'(period);
    tick     = enable && (m_cnt >= p - 1);
    m_cnt    = (!enable || tick) ? 0 : m_cnt + 1;
    was_full = (m_q.size() == DEPTH);
    pop      = (m_phase == 0) && tick && (m_q.size() != 0);
    ur_ev    = (m_phase == 0) && tick && (m_q.size() == 0);
    ms_ev    = tick && (m_phase != 0);
    if (pop) m_data = m_q.pop_front();
    if (wr_en && (!was_full || pop)) m_q.push_back(wr_data);
    case (m_phase)
      0:       if (pop) m_phase = 1;
      1:       m_phase = 2;
      default: if (dac_done) m_phase = 0;
    endcase
    m_ur = ur_ev || (m_ur && !clr_flags);
    m_ms = ms_ev || (m_ms && !clr_flags);
  endtask

  task automatic checkOutput();
    checkValue("model dac_data", dac_data, m_data);
    checkValue("model dac_start", dac_start, (m_phase == 1) ? 1 : 0);
    checkValue("model level", level, m_q.size());
    checkValue("model full", full, (m_q.size() == DEPTH) ? 1 : 0);
    checkValue("model empty", empty, (m_q.size() == 0) ? 1 : 0);
    checkValue("model busy", busy, (m_phase != 0) ? 1 : 0);
    checkValue("model underrun", underrun, m_ur);
    checkValue("model missed", missed, m_ms);
  endtask

  task automatic applyStimulus(input logic nr, input logic we, input logic [7:0] wd,
                               input logic en, input logic [15:0] per,
                               input logic clr, input logic done);
    n_reset   = nr;
    wr_en     = we;
    wr_data   = wd;
    enable    = en;
    period    = per;
    clr_flags = clr;
    dac_done  = done;
    modelStep();
    @(posedge sclk);
    #1;
    cyc++;
    checkOutput();
  endtask

  task automatic noteStart();
    if (dac_start) begin
      got.push_back(dac_data);
      n_starts++;
      done_cycle = cyc + 1 + done_delay;
    end
  endtask

  task automatic runDrain(input int per, input int want, input int budget, input string tag);
    int k = 0;
    while ((n_starts < want || busy) && k < budget) begin
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 16'(per), 1'b0, (cyc + 1 == done_cycle));
      noteStart();
      k++;
    end
    if (k >= budget) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s timeout: got %0d starts, expected %0d within %0d cycles",
               tag, n_starts, want, budget);
    end
  endtask

  task automatic startSequence();
    got.delete();
    n_starts   = 0;
    done_cycle = -1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'd1, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Single-sample transfer with period 4, done two cycles into WAIT, then flag handling.
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 16'd4, 1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 8'h33, 1'b0, 16'd4, 1'b0, 1'b0, 8'h00, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 16'd4, 1'b0, 1'b0, 8'h00, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 16'd4, 1'b0, 1'b0, 8'h00, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 16'd4, 1'b0, 1'b0, 8'h00, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 16'd4, 1'b0, 1'b0, 8'h33, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 16'd4, 1'b0, 1'b0, 8'h33, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 16'd4, 1'b0, 1'b0, 8'h33, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 16'd4, 1'b0, 1'b1, 8'h33, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 16'd4, 1'b0, 1'b0, 8'h33, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 16'd4, 1'b0, 1'b1, 8'h33, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 16'd4, 1'b0, 1'b0, 8'h33, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 16'd4, 1'b0, 1'b0, 8'h33, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 16'd4, 1'b1, 1'b0, 8'h33, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 16'd4, 1'b1, 1'b0, 8'h33, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].n_reset, vecs[i].wr_en, vecs[i].wr_data, vecs[i].enable,
                    vecs[i].period, vecs[i].clr_flags, vecs[i].dac_done);
      checkValue($sformatf("vec%0d dac_data", i), dac_data, vecs[i].exp_data);
      checkValue($sformatf("vec%0d dac_start", i), dac_start, vecs[i].exp_start);
      checkValue($sformatf("vec%0d level", i), level, vecs[i].exp_level);
      checkValue($sformatf("vec%0d busy", i), busy, vecs[i].exp_busy);
      checkValue($sformatf("vec%0d underrun", i), underrun, vecs[i].exp_underrun);
      checkValue($sformatf("vec%0d missed", i), missed, vecs[i].exp_missed);
    end

    // Overfill while stopped, then drain with prompt done pulses.
    startSequence();
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(i), 1'b0, 16'd1, 1'b0, 1'b0);
    end
    checkValue("seq2 full", full, 1);
    checkValue("seq2 level", level, 8);
    done_delay = 1;
    runDrain(1, 8, 200, "seq2");
    checkValue("seq2 count", got.size(), 8);
    for (int i = 0; i < 8; i++) begin
      checkValue($sformatf("seq2 order %0d", i), (i < got.size()) ? int'(got[i]) : -1, i + 1);
    end
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 16'd1, 1'b0, 1'b0);
    checkValue("seq2 underrun", underrun, 1);

    // Slow done handshake against a fast period: ticks are missed, samples are not lost.
    startSequence();
    applyStimulus(1'b1, 1'b1, 8'hA1, 1'b0, 16'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hA2, 1'b0, 16'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hA3, 1'b0, 16'd2, 1'b0, 1'b0);
    done_delay = 6;
    runDrain(2, 3, 300, "seq3");
    checkValue("seq3 missed", missed, 1);
    checkValue("seq3 count", got.size(), 3);
    for (int i = 0; i < 3; i++) begin
      checkValue($sformatf("seq3 order %0d", i), (i < got.size()) ? int'(got[i]) : -1, 8'hA1 + i);
    end

    // Write accepted while full because a pop happens in the same cycle.
    startSequence();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 8'(8'h10 + i), 1'b0, 16'd1, 1'b0, 1'b0);
    end
    done_delay = 1;
    applyStimulus(1'b1, 1'b1, 8'h18, 1'b1, 16'd1, 1'b0, 1'b0);
    noteStart();
    checkValue("seq4 level", level, 8);
    checkValue("seq4 full", full, 1);
    runDrain(1, 9, 300, "seq4");
    checkValue("seq4 count", got.size(), 9);
    for (int i = 0; i < 9; i++) begin
      checkValue($sformatf("seq4 order %0d", i), (i < got.size()) ? int'(got[i]) : -1, 8'h10 + i);
    end

    // Reset while waiting for done; the late done pulse must be ignored.
    startSequence();
    applyStimulus(1'b1, 1'b1, 8'h5A, 1'b0, 16'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 16'd1, 1'b0, 1'b0);
    checkValue("seq5 start", dac_start, 1);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 16'd1, 1'b0, 1'b0);
    checkValue("seq5 in wait", busy, 1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 16'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 16'd1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 16'd1, 1'b0, 1'b0);
      checkValue("seq5 busy", busy, 0);
      checkValue("seq5 dac_start", dac_start, 0);
      checkValue("seq5 empty", empty, 1);
      checkValue("seq5 dac_data", dac_data, 0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 99) != 0),
                    1'($urandom_range(0, 1)),
                    8'($urandom_range(0, 255)),
                    ($urandom_range(0, 7) != 0),
                    16'($urandom_range(0, 5)),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 3) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_sample_sequencer.md
Name: dac_sample_sequencer

Overview:
- Upstream feeder for the SPI DAC interface: buffers 8-bit samples in a small FIFO and releases them at a programmable sample rate.
- Drives the DAC interface's data/start inputs.
- Waits for its done pulse before issuing the next transfer.
- Reports underrun (tick with no sample) and missed-tick (tick while a transfer is still in flight) as sticky flags.

Parameters:
- DEPTH, 8, FIFO depth in samples; power of 2, minimum 2.
- PW, 16, width of the sample-period input.

Ports:
- sclk  in  1  system clock; all logic on rising edge.
- n_reset  in  1  synchronous active-low reset.
- wr_en  in  1  write strobe for wr_data.
- wr_data  in  8  sample to enqueue.
- enable  in  1  run the sample-rate timer.
- period  in  PW  sample period in sclk cycles; 0 is treated as 1.
- clr_flags  in  1  clears underrun and missed.
- dac_done  in  1  transfer-complete pulse from the DAC interface.
- dac_data  out  8  sample presented to the DAC interface.
- dac_start  out  1  one-cycle start pulse to the DAC interface.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  transfer in flight (state START or WAIT).
- underrun  out  1  sticky underrun flag.
- missed  out  1  sticky missed-tick flag.

Behaviour:
- Reset is synchronous: when n_reset=0 at a sclk edge, the following values apply.
  - state=IDLE, FIFO pointers=0, level=0, empty=1, full=0.
  - dac_data=0, dac_start=0, busy=0, underrun=0, missed=0.
  - Timer count=0.
  - Reset has priority over every other input.
  - Reset mid-transfer returns to IDLE immediately.
  - A later dac_done is ignored in IDLE.
- FIFO:
  - Write is accepted when wr_en=1 and (full=0 or a pop occurs in the same cycle).
  - A write while full with no pop is dropped silently; contents are unchanged.
  - Pointers wrap modulo DEPTH.
  - level updates on the next edge: +1 on write only, -1 on pop only, unchanged on both.
  - full = (level==DEPTH); empty = (level==0). Both are registered-consistent with level.
  - There is no write-to-read bypass. A sample written on a tick cycle while the FIFO is empty is not popped that tick.
- Timer:
  - While enable=1, count increments each cycle.
  - When count >= max(period,1)-1: internal tick=1 for that cycle, and count reloads to 0.
  - While enable=0: count forced to 0, no ticks.
  - With period=1 (or 0), tick is asserted every cycle.
  - A change to period takes effect from the next comparison.
- State machine (IDLE, START, WAIT):
  - IDLE, tick, empty=0: pop the FIFO head into dac_data at the edge; go to START.
  - IDLE, tick, empty=1: underrun<=1; dac_data holds its last value; stay IDLE; no start.
  - START: dac_start=1 for exactly this one cycle. Unconditionally go to WAIT; dac_done is ignored in START.
  - WAIT: on dac_done=1, go to IDLE at the edge.
  - A tick in START or WAIT sets missed<=1. No pop occurs; the sample stays queued for the next tick served in IDLE.
- Latency: tick in cycle N → dac_data valid and dac_start=1 in cycle N+1.
- dac_data is stable from START until the next pop.
- enable may drop mid-transfer; the in-flight transfer completes normally.
- clr_flags=1 clears both flags at the edge. If a set event occurs in the same cycle, set wins.
- dac_start is registered (derived from state==START); there is no combinational path from inputs.

Test Plan:
- Reset, write 0x33, enable=1, period=4, dac_done pulsed 3 cycles after dac_start → exactly one dac_start, with dac_data=0x33 on the cycle after the first tick. Then empty=1, busy returns to 0, and underrun=1 on the next tick.
- Write 9 samples 0x01..0x09 with DEPTH=8, enable=0 → full=1, level=8, and 0x09 dropped. Then enable with prompt done pulses → dac_data sequence 0x01..0x08, then underrun=1.
- period=2, dac_done returned 6 cycles after each start, FIFO preloaded with 3 samples → missed=1. All 3 samples still emitted in order, none lost.
- Simultaneous wr_en with pop while full → level stays 8, the new sample is appended, and order is preserved.
- n_reset=0 during WAIT, then dac_done pulse after release → state IDLE, FIFO empty, all outputs 0, and no spurious dac_start.
- clr_flags asserted in the same cycle as an underrun tick → underrun remains 1. clr_flags on a later quiet cycle → underrun=0 and missed=0.
